button_input_ctrl: RTL
======================

// Module: button_input_ctrl
//
// PURPOSE
// Front-end conditioning for the five board push-buttons ahead of the processor's
// difficulty_in input and the VGA controller's button inputs. Synchronises and
// debounces each raw button and emits clean levels plus one-cycle press pulses.
// Maintains the 32-bit difficulty register (L=1, C=2, R=3). Selections are
// accepted only while the game is in the menu state (game_state == 0).
//
// PARAMETERS
// NUM_BTN          5       number of buttons; fixed order {BTNU,BTND,BTNR,BTNC,BTNL}
// DEBOUNCE_CYCLES  500000  cycles a synced input must differ from the stable value to be accepted (10 ms @ 50 MHz)
// CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// DIFF_DEFAULT     1       difficulty value after reset
//
// PORTS
// clock             in   1        system clock (clk_50mHz)
// anti_reset        in   1        asynchronous reset, active-low
// btn_raw           in   NUM_BTN  raw, asynchronous button pins; bit0=BTNL .. bit4=BTNU
// game_state        in   32       game state from the regfile; 0 = menu
// btn_level         out  NUM_BTN  debounced button levels
// btn_press         out  NUM_BTN  one-cycle pulse on each debounced 0->1 edge
// difficulty        out  32       selected difficulty (1/2/3)
// difficulty_valid  out  1        high once any selection has been accepted since reset
//
// BEHAVIOUR
// - Reset (anti_reset low, asynchronous) sets:
//   sync FFs=0, counters=0, btn_level=0, btn_press=0,
//   difficulty=DIFF_DEFAULT, difficulty_valid=0.
// - Synchroniser: 2-FF chain per bit; btn_sync is the second stage.
// - Debounce, per bit, independent of other bits:
//   - btn_sync == btn_level: counter <= 0.
//   - btn_sync != btn_level and counter == DEBOUNCE_CYCLES-1:
//     btn_level <= btn_sync, counter <= 0.
//   - otherwise: counter <= counter + 1.
//   - Any return of sync to the stable value before the terminal count clears the
//     counter, so glitches shorter than DEBOUNCE_CYCLES cycles never reach btn_level.
//   - Release is debounced identically to press.
// - Latency: a raw edge held steady appears on btn_level 2 + DEBOUNCE_CYCLES clocks
//   later (±1 for synchroniser sampling).
// - btn_press[i] is registered: high for exactly the one cycle in which btn_level[i]
//   first reads 1. No pulse on release. No repeat while held.
// - Difficulty update, evaluated on the cycle btn_press is high; takes effect on the
//   next edge:
//   - Accepted only when game_state == 32'd0; otherwise the press is ignored and
//     difficulty holds.
//   - Priority on simultaneous presses: L (1) > C (2) > R (3).
//   - BTNU/BTND never affect difficulty.
//   - An accepted press sets difficulty_valid <= 1; it stays set until reset.
//   - Re-selecting the current value is legal: valid is set, value unchanged.
// - game_state changing while a button is held has no effect; only the press edge is
//   qualified.
// - Reset asserted mid-debounce aborts the count; a button still held when reset
//   releases is debounced afresh and then produces a press pulse.
// - No combinational path from any input to any output.
//
// TESTING (DEBOUNCE_CYCLES=8, CNT_W=4 for simulation)
// 1 Reset: anti_reset=0 -> difficulty=1, valid=0, btn_level=0, btn_press=0; hold for
//   20 cycles with buttons toggling -> outputs unchanged.
// 2 Clean press: BTNC held high, game_state=0 -> btn_level[1] rises 10±1 clocks later;
//   btn_press[1] high for 1 cycle; next cycle difficulty=2, valid=1.
// 3 Glitch: BTNR high for 5 cycles then low -> btn_level stays 0, no press pulse,
//   difficulty unchanged.
// 4 In-game lockout: game_state=2, BTNL press -> btn_press[0] pulses, difficulty stays 2.
//   Then game_state=0 and BTNL pressed again -> difficulty=1.
// 5 Simultaneous: BTNL and BTNR pressed on the same cycle in menu -> both press bits
//   pulse; difficulty=1.
// 6 Async reset mid-count: BTNR held, anti_reset pulsed low at count 4 -> counter
//   cleared immediately. After release of reset, press arrives 10±1 clocks later and
//   sets difficulty=3.

Source files
------------

// File: rtl/button_input_ctrl.sv
// rtl/button_input_ctrl.sv - button synchroniser/debouncer with press pulses and menu difficulty register
module button_input_ctrl #(
  parameter int          NUM_BTN         = 5,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          CNT_W           = 20,
  parameter logic [31:0] DIFF_DEFAULT    = 32'd1
) (
  input  logic               clock,
  input  logic               anti_reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [31:0]        game_state,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [31:0]        difficulty,
  output logic               difficulty_valid
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [31:0]        diff_q, diff_d;
  logic               valid_q, valid_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == TERM_CNT) level_d[i] = sync2_q[i];
        else                      cnt_d[i]   = cnt_q[i] + 1'b1;
      end
    end
    press_d = level_d & ~level_q;

    // Bits 0/1/2 are L/C/R; only the registered press edge is qualified by the menu state.
    diff_d  = diff_q;
    valid_d = valid_q;
    if ((game_state == 32'd0) && (|press_q[2:0])) begin
      valid_d = 1'b1;
      if (press_q[0])      diff_d = 32'd1;
      else if (press_q[1]) diff_d = 32'd2;
      else                 diff_d = 32'd3;
    end
  end

  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      diff_q  <= DIFF_DEFAULT;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      diff_q  <= diff_d;
      valid_q <= valid_d;
    end
  end

  assign btn_level        = level_q;
  assign btn_press        = press_q;
  assign difficulty       = diff_q;
  assign difficulty_valid = valid_q;

endmodule
